cnn_relu_maxpool: RTL and testbench



---
 rtl/cnn_pkg.sv | 19 +
 rtl/cnn_sync_fifo.sv | 62 ++++++
 rtl/cnn_relu_maxpool.sv | 98 +++++++++
 tb/tb_cnn_relu_maxpool.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the post-convolution stages.
package cnn_pkg;

  localparam int CONV_W    = 22;  // width of the conv core's ConvResult
  localparam int CNN_OUT_W = 16;  // default pooled output width
  localparam logic [CNN_OUT_W-1:0] SAT_MAX = {CNN_OUT_W{1'b1}};

  // ReLU then clamp to 2^w-1. The input is a sign-extended 32-bit value.
  // The caller keeps the low w bits of the result. w must be 31 or less.
  function automatic logic [31:0] relu_sat(input logic signed [31:0] x,
                                           input int unsigned w);
    logic [31:0] lim;
    lim = (32'd1 << w) - 32'd1;
    if (x < 0)                 return 32'd0;
    else if ($unsigned(x) > lim) return lim;
    else                       return $unsigned(x);
  endfunction

endpackage

// File: rtl/cnn_sync_fifo.sv
// Synchronous FIFO with registered dout, a one-cycle valid pulse, and
// registered full/empty flags. A push into a full FIFO succeeds only when
// a pop happens in the same cycle. Otherwise the push is dropped and drop_o
// flags it. A pop while the FIFO is empty is ignored.
module cnn_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q, full_q, empty_q;
  logic             pop_ok, push_ok;

  assign pop_ok  = pop_i && !empty_q;
  assign push_ok = push_i && (!full_q || pop_ok);
  assign drop_o  = push_i && !push_ok;
  assign wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
  assign rd_d    = pop_ok  ? rd_q + 1'b1 : rd_q;

  // Storage array. The pointers qualify its contents, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  // Pointers, read port and flags. The flags reflect occupancy after this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      valid_q <= pop_ok;
      if (pop_ok) dout_q <= mem_q[rd_q[AW-1:0]];
      empty_q <= (wr_d == rd_d);
      full_q  <= (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
    end
  end

  assign dout_o  = dout_q;
  assign valid_o = valid_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/cnn_relu_maxpool.sv
// Stage after the convolution core. It applies ReLU and saturation to each
// result, max-pools over windows of POOL_LEN results, and buffers the pooled
// values for the downstream reader.
module cnn_relu_maxpool
  import cnn_pkg::*;
#(
  parameter int IN_W     = CONV_W,
  parameter int OUT_W    = CNN_OUT_W,
  parameter int POOL_LEN = 3,
  parameter int DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Start,
  input  logic                   InValid,
  input  logic signed [IN_W-1:0] InData,
  input  logic                   ReadEn,
  output logic [OUT_W-1:0]       OutData,
  output logic                   OutValid,
  output logic                   Empty,
  output logic                   Full,
  output logic                   Overflow
);
  localparam int CW = (POOL_LEN > 1) ? $clog2(POOL_LEN) : 1;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] max_q, max_d;
  logic             start_d_q, ovf_q;
  logic             accept, last, flush;
  logic             push;
  logic [OUT_W-1:0] push_val, r, m_next;
  logic signed [31:0] in_ext;
  logic [31:0]      r_full;
  logic             drop;

  assign in_ext = {{(32-IN_W){InData[IN_W-1]}}, InData};
  assign r_full = relu_sat(in_ext, OUT_W);
  assign r      = r_full[OUT_W-1:0];

  assign accept = Start && InValid;
  assign last   = (cnt_q == CW'(POOL_LEN - 1));
  // A flush requires Start low, so it never coincides with an accept.
  assign flush  = start_d_q && !Start && (cnt_q != '0);
  assign m_next = (cnt_q == '0) ? r : ((r > max_q) ? r : max_q);

  // Next state of the window: close it on the last sample or on a flush.
  always_comb begin
    cnt_d    = cnt_q;
    max_d    = max_q;
    push     = 1'b0;
    push_val = m_next;
    if (accept) begin
      if (last) begin
        push  = 1'b1;
        cnt_d = '0;
        max_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        max_d = m_next;
      end
    end else if (flush) begin
      push     = 1'b1;
      push_val = max_q;
      cnt_d    = '0;
      max_d    = '0;
    end
  end

  // Window state, Start edge detector and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      max_q     <= '0;
      start_d_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      start_d_q <= Start;
      if (drop) ovf_q <= 1'b1;
    end
  end

  cnn_sync_fifo #(.WIDTH(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_val),
    .pop_i   (ReadEn),
    .dout_o  (OutData),
    .valid_o (OutValid),
    .full_o  (Full),
    .empty_o (Empty),
    .drop_o  (drop)
  );

  assign Overflow = ovf_q;
endmodule

// File: tb/tb_cnn_relu_maxpool.sv
// Directed bench for cnn_relu_maxpool with default parameters
// (POOL_LEN=3, DEPTH=4, OUT_W=16).
module tb_cnn_relu_maxpool;
  logic               clk = 1'b0;
  logic               rst, Start, InValid, ReadEn;
  logic signed [21:0] InData;
  logic [15:0]        OutData;
  logic               OutValid, Empty, Full, Overflow;
  int n_cmp = 0;
  int n_err = 0;

  cnn_relu_maxpool dut (
    .clk(clk), .rst(rst), .Start(Start), .InValid(InValid), .InData(InData),
    .ReadEn(ReadEn), .OutData(OutData), .OutValid(OutValid), .Empty(Empty),
    .Full(Full), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic smp(input int v);
    Start = 1'b1; InValid = 1'b1; InData = 22'(v);
    tick();
    InValid = 1'b0;
  endtask

  task automatic rd();
    ReadEn = 1'b1;
    tick();
    ReadEn = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; Start = 1'b0; InValid = 1'b0; InData = '0; ReadEn = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_outdata", 32'(OutData), 0);
    chk("rst_outvalid", 32'(OutValid), 0);
    chk("rst_empty", 32'(Empty), 1);
    chk("rst_full", 32'(Full), 0);
    chk("rst_overflow", 32'(Overflow), 0);

    // Window 5, -7, 12.
    smp(5); smp(-7);
    chk("w1_empty_mid", 32'(Empty), 1);
    smp(12);
    chk("w1_empty_after", 32'(Empty), 0);
    rd();
    chk("w1_data", 32'(OutData), 12);
    chk("w1_valid", 32'(OutValid), 1);
    chk("w1_empty_rd", 32'(Empty), 1);
    tick();
    chk("w1_valid_pulse", 32'(OutValid), 0);

    // All negative: the window pools to 0.
    smp(-1); smp(-2); smp(-3);
    rd();
    chk("neg_data", 32'(OutData), 0);
    chk("neg_valid", 32'(OutValid), 1);

    // Saturation.
    smp(70000); smp(3); smp(1);
    rd();
    chk("sat1_data", 32'(OutData), 65535);
    smp(7); smp(2); smp(5);
    rd();
    chk("plain_data", 32'(OutData), 7);
    smp(65535); smp(65536); smp(0);
    rd();
    chk("sat2_data", 32'(OutData), 65535);

    // Partial window flushed on Start falling, then an empty Start pulse.
    smp(4); smp(9);
    Start = 1'b0; tick();
    chk("flush_empty", 32'(Empty), 0);
    rd();
    chk("flush_data", 32'(OutData), 9);
    Start = 1'b1; tick(); Start = 1'b0; tick(); tick();
    chk("noflush_empty", 32'(Empty), 1);

    // Fill the FIFO, then overflow it.
    for (int w = 0; w < 5; w++) begin
      smp(3*w+1); smp(3*w+2); smp(3*w+3);
      if (w == 3) begin
        chk("fill_full", 32'(Full), 1);
        chk("fill_ovf_clear", 32'(Overflow), 0);
      end
    end
    chk("ovf_set", 32'(Overflow), 1);
    chk("ovf_full", 32'(Full), 1);
    for (int k = 0; k < 4; k++) begin
      rd();
      chk("drain_data", 32'(OutData), 32'(3*k+3));
      chk("drain_valid", 32'(OutValid), 1);
    end
    chk("drain_empty", 32'(Empty), 1);
    rd();
    chk("extra_rd_valid", 32'(OutValid), 0);
    chk("extra_rd_hold", 32'(OutData), 12);
    chk("ovf_sticky", 32'(Overflow), 1);

    // Reset in the middle of a window discards the partial window.
    do_reset();
    chk("rst2_ovf", 32'(Overflow), 0);
    smp(8); smp(3);
    do_reset();
    smp(1); smp(2); smp(3);
    chk("rstmid_empty", 32'(Empty), 0);
    chk("rstmid_ovf", 32'(Overflow), 0);
    rd();
    chk("rstmid_data", 32'(OutData), 3);
    chk("rstmid_single", 32'(Empty), 1);

    // A push and a pop in the same cycle while the FIFO is full.
    for (int w = 0; w < 4; w++) begin
      smp(3*w+1); smp(3*w+2); smp(3*w+3);
    end
    chk("coll_full_pre", 32'(Full), 1);
    smp(20); smp(22);
    ReadEn = 1'b1;
    smp(21);
    ReadEn = 1'b0;
    chk("coll_valid", 32'(OutValid), 1);
    chk("coll_data", 32'(OutData), 3);
    chk("coll_full", 32'(Full), 1);
    chk("coll_ovf", 32'(Overflow), 0);
    rd(); chk("coll_d1", 32'(OutData), 6);
    rd(); chk("coll_d2", 32'(OutData), 9);
    rd(); chk("coll_d3", 32'(OutData), 12);
    rd(); chk("coll_d4", 32'(OutData), 22);
    chk("coll_empty", 32'(Empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
